// File: rtl/cnn_bram_pkg.sv
// cnn_bram_pkg: shared constants and reader FSM state for the CNN feature-map BRAM readers
package cnn_bram_pkg;
    localparam int BYTES_PER_WORD   = 4;
    localparam int WORD_ADDR_STRIDE = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t;
endpackage

// File: rtl/conv2_rd_fifo.sv
// conv2_rd_fifo: small synchronous FIFO with occupancy count; head word readable combinationally
module conv2_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
endmodule

// File: rtl/conv2_fmap_bram_reader.sv
// conv2_fmap_bram_reader: streams Conv2D_2 feature-map words from BRAM port B as little-endian bytes
module conv2_fmap_bram_reader
    import cnn_bram_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      bram_addr,
    output logic             bram_en,
    output logic [3:0]       bram_we,
    output logic [31:0]      bram_din,
    input  logic [31:0]      bram_dout,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    rd_state_t             state;
    logic [31:0]           base;
    logic [CNT_W-1:0]      cnt, issued, words_out;
    logic [1:0]            byte_idx;
    logic [RD_LATENCY-1:0] pipe;
    logic [FAW:0]          fifo_count;
    logic [31:0]           head;
    logic [7:0]            in_flight;
    logic                  fire, pop, last_byte;
    assign bram_we   = '0;
    assign bram_din  = '0;
    assign m_valid   = fifo_count != '0;
    assign fire      = m_valid && m_ready;
    assign last_byte = byte_idx == 2'(BYTES_PER_WORD - 1);
    assign pop       = fire && last_byte;
    assign m_data    = m_valid ? head[{byte_idx, 3'b000} +: 8] : '0;
    assign m_last    = m_valid && last_byte && words_out == cnt - 1'b1;
    assign bram_addr = base + 32'(issued) * 32'(WORD_ADDR_STRIDE);
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + 8'(pipe[i]);
    end
    // Credit covers both queued words and reads still in the BRAM pipe, so captures never overflow.
    assign bram_en = state == RUN && issued < cnt && in_flight + 8'(fifo_count) < 8'(FIFO_DEPTH);
    conv2_rd_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe[RD_LATENCY-1]),
        .wr_data (bram_dout),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            base      <= '0;
            cnt       <= '0;
            issued    <= '0;
            words_out <= '0;
            byte_idx  <= '0;
            pipe      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pipe <= RD_LATENCY'({pipe, bram_en});
            done <= 1'b0;
            if (bram_en) issued <= issued + 1'b1;
            if (fire) byte_idx <= byte_idx + 1'b1;
            if (pop) words_out <= words_out + 1'b1;
            case (state)
                IDLE: if (start) begin
                    base      <= base_addr;
                    cnt       <= word_count;
                    issued    <= '0;
                    words_out <= '0;
                    byte_idx  <= '0;
                    busy      <= 1'b1;
                    // An empty transfer still spends one busy cycle so done lands two cycles after start.
                    state     <= word_count == '0 ? DRAIN : RUN;
                end
                RUN: if (bram_en && issued == cnt - 1'b1) state <= DRAIN;
                DRAIN: if (cnt == '0 || (fire && m_last)) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2_fmap_bram_reader.sv
// tb_conv2_fmap_bram_reader: table-driven and randomized checks against a byte-queue reference model
module tb_conv2_fmap_bram_reader;
    localparam int RL = 2;
    localparam int FD = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, bram_en, busy, done, m_valid, m_ready, m_last;
    logic [31:0]   base_addr, bram_addr, bram_din, bram_dout, r1, r2;
    logic [CW-1:0] word_count;
    logic [3:0]    bram_we;
    logic [7:0]    m_data;
    int            n_cmp = 0;
    int            n_bad = 0;

    typedef struct {
        logic [31:0] base;
        int          cnt;
        int          mode;
        bit          pulse;
        int          exp_first;
    } vec_t;

    conv2_fmap_bram_reader #(.RD_LATENCY(RL), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bram_addr  (bram_addr),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_din   (bram_din),
        .bram_dout  (bram_dout),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0] ^ 8'h5A, a[15:8] + 8'h33, a[9:2] * 8'd7 + 8'h11, ~a[7:0]};
    endfunction

    // BRAM port B with output register: two-cycle read latency, deliberately never reset.
    always_ff @(posedge clk) begin
        if (bram_en) r1 <= mem_word(bram_addr);
        r2 <= r1;
    end
    assign bram_dout = r2;

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return cyc[0];
            2:       return 1'($urandom_range(0, 1));
            default: return logic'(cyc > 50);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_en"}, 32'(bram_en), 0);
        check({tag, "_addr"}, bram_addr, 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_last"}, 32'(m_last), 0);
        check({tag, "_data"}, 32'(m_data), 0);
    endtask

    task automatic run_xfer(input logic [31:0] b, input int cnt, input int mode, input bit pulse,
                            input int exp_first);
        logic [7:0]  exp_q[$];
        logic [31:0] w;
        logic [7:0]  pd;
        logic        pl;
        int          issued = 0, popped = 0, nbytes = 0, first_v = -1, last_cyc = -1, lim;
        bit          stalled = 1'b0, got_done = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            w = mem_word(b + 32'(4 * i));
            for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
        end
        lim = 60 + 12 * cnt;
        start = 1'b1;
        base_addr = b;
        word_count = CW'(cnt);
        m_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= lim && !got_done; cyc++) begin
            m_ready = ready_for(mode, cyc);
            if (pulse && cyc == 3) begin
                start = 1'b1;
                base_addr = 32'hDEAD_0000;
                word_count = CW'(7);
            end
            if (pulse && cyc == 4) start = 1'b0;
            @(negedge clk);
            if (cyc == 1) check("busy_after_start", 32'(busy), 1);
            if (cyc == 1 && cnt > 0) check("first_en", 32'(bram_en), 1);
            if (bram_en) begin
                if (issued < cnt) check("rd_addr", bram_addr, b + 32'(4 * issued));
                else check("read_count", 32'(issued + 1), 32'(cnt));
                issued++;
                check("credit", 32'(issued - popped <= FD), 1);
            end
            if (mode == 3 && cyc == 50) check("stall_reads", 32'(issued), FD);
            if (stalled) begin
                check("hold_valid", 32'(m_valid), 1);
                check("hold_data", 32'(m_data), 32'(pd));
                check("hold_last", 32'(m_last), 32'(pl));
            end
            if (m_valid && first_v < 0) first_v = cyc;
            if (m_valid && m_ready) begin
                if (nbytes < 4 * cnt) begin
                    check("byte", 32'(m_data), 32'(exp_q[nbytes]));
                    check("last", 32'(m_last), 32'(nbytes == 4 * cnt - 1));
                end else check("byte_count", 32'(nbytes + 1), 32'(4 * cnt));
                nbytes++;
                if (nbytes % 4 == 0) popped++;
                if (nbytes == 4 * cnt) last_cyc = cyc;
            end
            stalled = m_valid && !m_ready;
            pd = m_data;
            pl = m_last;
            if (done) begin
                got_done = 1'b1;
                check("done_cycle", 32'(cyc), 32'(cnt == 0 ? 2 : last_cyc + 1));
                check("busy_at_done", 32'(busy), 0);
                if (pulse) start = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        check("done_pulse_width", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
        check("done_seen", 32'(got_done), 1);
        check("total_bytes", 32'(nbytes), 32'(4 * cnt));
        check("total_reads", 32'(issued), 32'(cnt));
        if (exp_first >= 0) check("first_valid_cycle", 32'(first_v), 32'(exp_first));
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        logic [31:0] rb;
        vecs = '{
            '{32'h0000_0100, 3, 0, 1'b0, RL + 2},
            '{32'h0000_0100, 3, 1, 1'b0, -1},
            '{32'h0000_0100, 3, 0, 1'b1, -1},
            '{32'hFFFF_FFF8, 4, 0, 1'b0, RL + 2},
            '{32'h0000_0040, 8, 3, 1'b0, -1},
            '{32'h0000_0080, 0, 0, 1'b0, -1}
        };
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        word_count = '0;
        m_ready = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        check("reset_we", 32'(bram_we), 0);
        check("reset_din", bram_din, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].pulse, vecs[v].exp_first);
        // Reset while two reads are in flight, then a clean single-word transfer.
        start = 1'b1;
        base_addr = 32'h0000_0200;
        word_count = CW'(6);
        m_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_xfer(32'h0000_0300, 1, 0, 1'b0, RL + 2);
        for (int r = 0; r < 6; r++) begin
            rb = $urandom();
            rb[1:0] = 2'b00;
            run_xfer(rb, int'($urandom_range(1, 9)), 2, 1'b0, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
